// File: rtl/utlb.sv
// utlb: four-entry fully-associative micro-TLB in front of one MMU search port.
// Fetch hits resolve in one cycle; misses go to the shared MMU, return the
// result with fault flags, and install clean translations round-robin.
module utlb #(
  parameter int ENTRY_NUM = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_vaddr_i,
  input  logic [9:0]  asid_i,
  input  logic [1:0]  plv_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_paddr_o,
  output logic [1:0]  resp_mat_o,
  output logic        resp_tlbr_o,
  output logic        resp_pif_o,
  output logic        resp_ppi_o,
  output logic        mmu_req_valid_o,
  output logic [31:0] mmu_vaddr_o,
  input  logic        mmu_gnt_i,
  input  logic        mmu_found_i,
  input  logic        mmu_v_i,
  input  logic [1:0]  mmu_plv_i,
  input  logic [1:0]  mmu_mat_i,
  input  logic [31:0] mmu_paddr_i
);

  localparam int IDX_W = $clog2(ENTRY_NUM);

  typedef enum logic {S_IDLE, S_MISS} state_t;

  typedef struct packed {
    logic [19:0] vpn;
    logic [9:0]  asid;
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
  } entry_t;

  state_t               state;
  logic [ENTRY_NUM-1:0] val;
  entry_t               ent [ENTRY_NUM];
  logic [IDX_W-1:0]     rr;
  logic                 no_install;
  logic [9:0]           miss_asid;
  logic [1:0]           miss_plv;

  logic                 hit;
  entry_t               hit_ent;
  logic                 grant;
  logic                 install;

  assign req_ready_o = (state == S_IDLE);
  assign grant       = (state == S_MISS) && mmu_gnt_i;
  // A flush in the grant cycle also blocks the install: the flush wins the edge.
  assign install     = grant && mmu_found_i && mmu_v_i && !no_install && !flush_i;

  // Associative lookup; tags are unique so at most one entry matches.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    hit     = 1'b0;
    hit_ent = '0;
    for (int i = 0; i < ENTRY_NUM; i++) begin
      if (val[i] && ent[i].vpn == req_vaddr_i[31:12] && ent[i].asid == asid_i && !flush_i) begin
        hit     = 1'b1;
        hit_ent = ent[i];
      end
    end
  end

  // Valid bits and victim pointer: flush clears everything, install sets one slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
      rr  <= '0;
    end else if (flush_i) begin
      val <= '0;
    end else if (install) begin
      val[rr] <= 1'b1;
      rr      <= rr + IDX_W'(1);
    end
  end

  // Entry payload written on install.
  // NOTE: the payload array is not reset; the valid bits alone guard its contents.
  always_ff @(posedge clk) begin
    if (install) begin
      ent[rr] <= '{vpn:  mmu_vaddr_o[31:12],
                   asid: miss_asid,
                   ppn:  mmu_paddr_i[31:12],
                   plv:  mmu_plv_i,
                   mat:  mmu_mat_i};
    end
  end

  // Control FSM with registered response and MMU request outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      no_install      <= 1'b0;
      miss_asid       <= '0;
      miss_plv        <= '0;
      mmu_req_valid_o <= 1'b0;
      mmu_vaddr_o     <= '0;
      resp_valid_o    <= 1'b0;
      resp_paddr_o    <= '0;
      resp_mat_o      <= '0;
      resp_tlbr_o     <= 1'b0;
      resp_pif_o      <= 1'b0;
      resp_ppi_o      <= 1'b0;
    end else begin
      resp_valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid_i) begin
            if (hit) begin
              resp_valid_o <= 1'b1;
              resp_paddr_o <= {hit_ent.ppn, req_vaddr_i[11:0]};
              resp_mat_o   <= hit_ent.mat;
              resp_tlbr_o  <= 1'b0;
              resp_pif_o   <= 1'b0;
              resp_ppi_o   <= (plv_i > hit_ent.plv);
            end else begin
              mmu_vaddr_o     <= req_vaddr_i;
              miss_asid       <= asid_i;
              miss_plv        <= plv_i;
              mmu_req_valid_o <= 1'b1;
              state           <= S_MISS;
            end
          end
        end
        S_MISS: begin
          if (flush_i) no_install <= 1'b1;
          if (mmu_gnt_i) begin
            resp_valid_o    <= 1'b1;
            resp_paddr_o    <= (mmu_found_i && mmu_v_i) ? mmu_paddr_i : 32'h0;
            resp_mat_o      <= mmu_mat_i;
            resp_tlbr_o     <= !mmu_found_i;
            resp_pif_o      <= mmu_found_i && !mmu_v_i;
            resp_ppi_o      <= mmu_found_i && mmu_v_i && (miss_plv > mmu_plv_i);
            mmu_req_valid_o <= 1'b0;
            no_install      <= 1'b0;
            state           <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_utlb.sv
// tb_utlb: directed and randomized checks of utlb against a translation-cache
// reference model (set of cached pages with a rotating replacement slot).
module tb_utlb;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [31:0] req_vaddr_i = '0;
  logic [9:0]  asid_i = '0;
  logic [1:0]  plv_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o;
  logic [31:0] resp_paddr_o;
  logic [1:0]  resp_mat_o;
  logic        resp_tlbr_o, resp_pif_o, resp_ppi_o;
  logic        mmu_req_valid_o;
  logic [31:0] mmu_vaddr_o;
  logic        mmu_gnt_i = 1'b0;
  logic        mmu_found_i = 1'b0;
  logic        mmu_v_i = 1'b0;
  logic [1:0]  mmu_plv_i = '0;
  logic [1:0]  mmu_mat_i = '0;
  logic [31:0] mmu_paddr_i = '0;

  int total = 0;
  int bad   = 0;

  utlb #(.ENTRY_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_vaddr_i(req_vaddr_i),
    .asid_i(asid_i), .plv_i(plv_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_paddr_o(resp_paddr_o), .resp_mat_o(resp_mat_o),
    .resp_tlbr_o(resp_tlbr_o), .resp_pif_o(resp_pif_o), .resp_ppi_o(resp_ppi_o),
    .mmu_req_valid_o(mmu_req_valid_o), .mmu_vaddr_o(mmu_vaddr_o), .mmu_gnt_i(mmu_gnt_i),
    .mmu_found_i(mmu_found_i), .mmu_v_i(mmu_v_i), .mmu_plv_i(mmu_plv_i),
    .mmu_mat_i(mmu_mat_i), .mmu_paddr_i(mmu_paddr_i)
  );

  always #5 clk = ~clk;

  // Reference model: cached translations plus the slot the next install replaces.
  typedef struct {
    bit          valid;
    logic [19:0] vpn;
    logic [9:0]  asid;
    logic [19:0] ppn;
    logic [1:0]  plv;
    logic [1:0]  mat;
  } xlat_t;

  xlat_t model [N];
  int    next_slot = 0;

  function automatic void model_clear();
    for (int i = 0; i < N; i++) model[i].valid = 1'b0;
  endfunction

  function automatic int model_find(input logic [31:0] va, input logic [9:0] as);
    for (int i = 0; i < N; i++)
      if (model[i].valid && model[i].vpn == va[31:12] && model[i].asid == as) return i;
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    step();
    check({tag, ":idle_resp"}, {31'b0, resp_valid_o}, 32'd0);
  endtask

  // One fetch lookup; the MMU answers (if asked) after 'delay' stall cycles.
  task automatic do_req(input string tag, input logic [31:0] va, input logic [9:0] as,
                        input logic [1:0] pl, input bit flush_acc, input int delay,
                        input bit flush_miss, input bit found, input bit v,
                        input logic [1:0] mplv, input logic [1:0] mmat, input logic [31:0] mpa);
    int idx;
    if (flush_acc) model_clear();
    idx = model_find(va, as);
    req_valid_i = 1'b1; req_vaddr_i = va; asid_i = as; plv_i = pl; flush_i = flush_acc;
    check({tag, ":ready"}, {31'b0, req_ready_o}, 32'd1);
    step();
    req_valid_i = 1'b0; flush_i = 1'b0;
    if (idx >= 0) begin
      check({tag, ":hit_valid"}, {31'b0, resp_valid_o}, 32'd1);
      check({tag, ":hit_nommu"}, {31'b0, mmu_req_valid_o}, 32'd0);
      check({tag, ":hit_paddr"}, resp_paddr_o, {model[idx].ppn, va[11:0]});
      check({tag, ":hit_mat"}, {30'b0, resp_mat_o}, {30'b0, model[idx].mat});
      check({tag, ":hit_flags"}, {29'b0, resp_tlbr_o, resp_pif_o, resp_ppi_o},
            {29'b0, 1'b0, 1'b0, pl > model[idx].plv});
    end else begin
      check({tag, ":miss_noresp"}, {31'b0, resp_valid_o}, 32'd0);
      check({tag, ":miss_req"}, {31'b0, mmu_req_valid_o}, 32'd1);
      check({tag, ":miss_vaddr"}, mmu_vaddr_o, va);
      check({tag, ":miss_busy"}, {31'b0, req_ready_o}, 32'd0);
      for (int d = 0; d <= delay; d++) begin
        flush_i = flush_miss && (d == 0);
        mmu_gnt_i = (d == delay);
        mmu_found_i = found; mmu_v_i = v; mmu_plv_i = mplv; mmu_mat_i = mmat; mmu_paddr_i = mpa;
        step();
        flush_i = 1'b0; mmu_gnt_i = 1'b0;
        if (d < delay) begin
          check({tag, ":stall_req"}, {31'b0, mmu_req_valid_o}, 32'd1);
          check({tag, ":stall_noresp"}, {31'b0, resp_valid_o}, 32'd0);
        end
      end
      check({tag, ":resp_valid"}, {31'b0, resp_valid_o}, 32'd1);
      check({tag, ":req_drop"}, {31'b0, mmu_req_valid_o}, 32'd0);
      check({tag, ":resp_flags"}, {29'b0, resp_tlbr_o, resp_pif_o, resp_ppi_o},
            {29'b0, !found, found && !v, found && v && (pl > mplv)});
      check({tag, ":resp_paddr"}, resp_paddr_o, (found && v) ? mpa : 32'h0);
      if (found && v) check({tag, ":resp_mat"}, {30'b0, resp_mat_o}, {30'b0, mmat});
      if (flush_miss) begin
        model_clear();
      end else if (found && v) begin
        model[next_slot] = '{1'b1, va[31:12], as, mpa[31:12], mplv, mmat};
        next_slot = (next_slot + 1) % N;
      end
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    model_clear();
    next_slot = 0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] va, pa;
    // Reset state
    model_clear();
    step();
    check("rst:ready", {31'b0, req_ready_o}, 32'd1);
    check("rst:resp", {26'b0, resp_valid_o, resp_tlbr_o, resp_pif_o, resp_ppi_o, resp_mat_o}, 32'd0);
    check("rst:paddr", resp_paddr_o, 32'd0);
    check("rst:mmu", {31'b0, mmu_req_valid_o}, 32'd0);
    check("rst:mmu_vaddr", mmu_vaddr_o, 32'd0);
    step();
    rst_n = 1'b1;

    // Miss then hit on the same page
    do_req("mh_miss", 32'h0040_1234, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 32'h1230_1234);
    do_req("mh_hit", 32'h0040_1ABC, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 32'h0);
    idle_check("mh");

    // Faults; tlbr and pif results are not cached
    do_req("tlbr", 32'h0080_2000, 10'd5, 2'd0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 32'h5555_5000);
    do_req("tlbr_again", 32'h0080_2000, 10'd5, 2'd0, 0, 1, 0, 0, 0, 2'd0, 2'd0, 32'h5555_5000);
    do_req("pif", 32'h0080_3000, 10'd5, 2'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 32'h6666_6000);
    do_req("pif_again", 32'h0080_3000, 10'd5, 2'd0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 32'h6666_6000);
    do_req("ppi", 32'h0080_4010, 10'd5, 2'd3, 0, 0, 0, 1, 1, 2'd0, 2'd2, 32'h7777_4010);
    do_req("ppi_hit", 32'h0080_4020, 10'd5, 2'd3, 0, 0, 0, 1, 1, 2'd0, 2'd2, 32'h0);
    do_req("noppi_hit", 32'h0080_4030, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd2, 32'h0);

    // Replacement wrap from a clean state
    apply_reset();
    for (int p = 1; p <= 5; p++) begin
      va = 32'h0100_0000 + (p << 12);
      pa = 32'hA000_0000 + (p << 12);
      do_req("fill", va, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd0, pa);
    end
    do_req("wrap_p2_hit", 32'h0100_2008, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd0, 32'h0);
    do_req("wrap_p1_miss", 32'h0100_1000, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd3, 32'hA000_1000);

    // Flush during a stalled miss, then flush alongside a request for a cached page
    do_req("fl_miss", 32'h0200_0000, 10'd5, 2'd0, 0, 3, 1, 1, 1, 2'd0, 2'd1, 32'hB000_0000);
    do_req("fl_again", 32'h0200_0004, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 32'hB000_0004);
    do_req("fl_cached", 32'h0200_0008, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 32'h0);
    do_req("fl_acc", 32'h0200_000C, 10'd5, 2'd0, 1, 0, 0, 1, 1, 2'd0, 2'd1, 32'hB000_000C);

    // ASID tagging
    do_req("asid5_hit", 32'h0200_0010, 10'd5, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd1, 32'h0);
    do_req("asid6_miss", 32'h0200_0010, 10'd6, 2'd0, 0, 0, 0, 1, 1, 2'd0, 2'd2, 32'hC000_0010);

    // Reset while the MMU request is outstanding
    req_valid_i = 1'b1; req_vaddr_i = 32'h0300_0000; asid_i = 10'd7; plv_i = 2'd0;
    step();
    req_valid_i = 1'b0;
    check("rmid:req_up", {31'b0, mmu_req_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rmid:req_drop", {31'b0, mmu_req_valid_o}, 32'd0);
    check("rmid:vaddr", mmu_vaddr_o, 32'd0);
    check("rmid:ready", {31'b0, req_ready_o}, 32'd1);
    check("rmid:resp", {31'b0, resp_valid_o}, 32'd0);
    model_clear();
    next_slot = 0;
    step();
    rst_n = 1'b1;
    mmu_gnt_i = 1'b1;
    idle_check("rmid_a");
    check("rmid:no_req", {31'b0, mmu_req_valid_o}, 32'd0);
    mmu_gnt_i = 1'b0;
    idle_check("rmid_b");

    // Randomized traffic over a small page pool
    for (int n = 0; n < 80; n++) begin
      va = 32'h0400_0000 + ($urandom_range(0, 5) << 12) + ($urandom & 32'hFFF);
      pa = $urandom;
      do_req("rnd", va, 10'($urandom_range(5, 6)), 2'($urandom), ($urandom % 10) == 0,
             $urandom_range(0, 3), ($urandom % 8) == 0, ($urandom % 5) != 0,
             ($urandom % 5) != 0, 2'($urandom), 2'($urandom), pa);
      if (($urandom % 4) == 0) idle_check("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/utlb.md
# utlb

Four-entry fully-associative micro-TLB between instruction fetch and one search port of the shared `mmu`. It caches successful 4 KB-granular mapped translations, tagged by ASID, so that fetch hits resolve in one cycle without occupying the MMU port. On a miss it issues a single request through the arbitrated MMU port, returns the result with fault flags, and installs valid translations. Direct and DMW addressing are resolved in fetch and never reach this block.

## Interface
- `ENTRY_NUM`, default 4: number of entries; must be a power of two, ≥2.
- `clk` input 1: clock.
- `rst_n` input 1: reset; asynchronous, active-low.
- `req_valid_i` input 1: fetch lookup request.
- `req_ready_o` output 1: block can accept a request; equals state==IDLE.
- `req_vaddr_i` input 32: virtual fetch address.
- `asid_i` input 10: current ASID.
- `plv_i` input 2: current privilege level.
- `flush_i` input 1: invalidate all entries (TLBWR/TLBFILL/INVTLB commit, or ASID/CRMD write).
- `resp_valid_o` output 1: one-cycle response pulse; the consumer is always ready.
- `resp_paddr_o` output 32: physical address; 0 when `resp_tlbr_o` or `resp_pif_o` is set.
- `resp_mat_o` output 2: memory access type.
- `resp_tlbr_o`, `resp_pif_o`, `resp_ppi_o` output 1 each: TLB refill, fetch page-invalid and privilege faults.
- `mmu_req_valid_o` output 1: MMU port request.
- `mmu_vaddr_o` output 32: latched miss address.
- `mmu_gnt_i` input 1: port granted; MMU response fields are valid in the grant cycle.
- `mmu_found_i`, `mmu_v_i` input 1 each; `mmu_plv_i` input 2; `mmu_mat_i` input 2; `mmu_paddr_i` input 32: MMU search result.

## Operation
- Entry fields:
  - `val`
  - `vpn[31:12]`
  - `asid`
  - `ppn[31:12]` (from `mmu_paddr_i`, so 4 MB pages are stored as 4 KB slices)
  - `plv`
  - `mat`
- Hit condition: `val` && vpn == vaddr[31:12] && asid == `asid_i` && !`flush_i`. At most one entry can hit.
- States:
  - IDLE: when `req_valid_i` is high, perform the lookup. On a hit, register the response and stay in IDLE. On a miss, latch vaddr, asid and plv, then go to MISS.
  - MISS: assert `mmu_req_valid_o` with `mmu_vaddr_o` held. On `mmu_gnt_i`, register the response and go to IDLE.
- Fault priority on an MMU result: `!found` → tlbr; else `!v` → pif; else `plv_i > mmu_plv_i` → ppi. Exactly one flag is set, or none.
- On a hit, ppi is evaluated against the entry plv and the current `plv_i`. A hit never raises tlbr or pif.
- Install on grant when found && v && no flush was seen since the miss was latched. Faulting results are never cached.
- Victim: round-robin pointer `rr`. After an install, `rr` = `rr`+1 mod `ENTRY_NUM`.
- `flush_i` clears every `val` at the next edge and sets a sticky `no_install` flag while in MISS. The in-flight miss still completes and responds, but does not install. The flag clears on return to IDLE.

## Timing
- Reset values:
  - all `val` = 0, `rr` = 0, state IDLE, `no_install` = 0
  - `resp_valid_o` = 0, all `resp_*` = 0
  - `mmu_req_valid_o` = 0, `mmu_vaddr_o` = 0
  - `req_ready_o` = 1
- Hit latency: `resp_valid_o` in the cycle after acceptance. Back-to-back hits sustain one request per cycle.
- Miss latency: `mmu_req_valid_o` rises the cycle after acceptance. The response arrives the cycle after `mmu_gnt_i`. A grant in the first MISS cycle gives 2-cycle latency.
- A newly installed entry is hittable for requests accepted from the cycle after the install edge.
- `mmu_req_valid_o` stays high until granted and deasserts in the cycle after the grant.
- Reset mid-MISS: asynchronous return to the reset values; no response is produced.
- Outputs are registered, except `req_ready_o`, which decodes the state register.

## Test plan
- Miss then hit:
  - Request vaddr 0x0040_1234, asid 5, plv 0; MMU grants immediately with found=1, v=1, plv=0, paddr 0x1230_1234, mat 1.
  - Required: response at accept+2 with paddr 0x1230_1234 and no flags.
  - Then vaddr 0x0040_1ABC → response 1 cycle later with paddr 0x1230_1ABC, `mmu_req_valid_o` never raised.
- Faults:
  - MMU found=0 → tlbr=1, paddr 0.
  - found=1, v=0 → pif=1.
  - found=1, v=1, page plv 0 with `plv_i`=3 → ppi=1.
  - Repeating the same address must miss again (faults not cached).
- Replacement wrap: fill 5 distinct pages. The 5th install evicts the entry of the 1st page (`rr` wraps 3→0), so a re-request of page 1 issues an MMU request.
- Flush: `flush_i` during MISS with grant delayed 3 cycles → response still delivered, no install, and the next same-page request misses. `flush_i` in the same cycle as a request for a cached page → miss.
- ASID: a cached page under asid 5 misses under asid 6.
- Reset mid-MISS: assert `rst_n`=0 asynchronously while `mmu_req_valid_o`=1 → `mmu_req_valid_o` and all outputs drop immediately, with no response after release.
